// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory load controller:
//   - default memory depth (32-bit words) and matching word-address width
//   - controller state encoding
//   - helper that flags a fetch PC that is not word aligned
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 64;
    localparam int IMEM_AW_DEFAULT    = 6;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,   // accepting image words from the loader
        ST_RUN  = 2'd1,   // image in place, CPU fetching
        ST_ERR  = 2'd2    // image overflowed the memory; held until reset
    } imem_state_e;

    // A fetch PC must point at a whole 32-bit word.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Boot-time loader for an external instruction memory. A streaming loader
// pushes an image one word per cycle (valid/ready); each accepted word is
// written at the next free word address. When the word flagged ld_last has
// been written the CPU is released and the memory address port follows the
// CPU fetch PC. An image longer than the memory drops into a sticky error
// state. A misaligned fetch PC while running raises the sticky err flag.
//
// Optional feature (macro IMEM_RELOAD_EN): reload_req while running returns
// the controller to LOAD so a fresh image can be written from word 0.
// Without the macro reload_req is ignored.
//
// Parameters
//   DEPTH      memory depth in 32-bit words (power of two)
//   AW         word-address width, log2(DEPTH)
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset
//   ld_valid   loader word valid
//   ld_ready   controller accepts a loader word (registered)
//   ld_data    instruction word to store
//   ld_last    final word of the image
//   cpu_pc     CPU byte-address fetch PC
//   cpu_stall  CPU must hold its PC (registered)
//   mem_we     memory write enable (registered)
//   mem_addr   memory word address: write address while loading, cpu_pc
//              word index (combinational) while running
//   mem_wdata  memory write data (registered)
//   boot_done  image loaded and CPU running (registered)
//   err        sticky overflow / misaligned-fetch error (registered)
//   reload_req request a new image load (IMEM_RELOAD_EN only)
// -----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int AW    = IMEM_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic [31:0]   cpu_pc,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          boot_done,
    output logic          err,
    input  logic          reload_req
);

    // Word index of the last slot in the memory.
    localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH - 1);

    imem_state_e   state;
    logic [AW:0]   wcnt;        // words accepted so far (one spare bit)
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic          boot_q;
    logic          stall_q;
    logic          ready_q;

    logic          handshake;
    logic          running;
    logic          reload_go;

    // ready_q is only ever high in LOAD; the state term keeps that explicit.
    assign handshake = ld_valid & ready_q & (state == ST_LOAD);

    // RUN is entered while the final image word is still being written; the
    // CPU is released (and the PC drives the address port) one cycle later.
    assign running = (state == ST_RUN) & ~stall_q;

`ifdef IMEM_RELOAD_EN
    assign reload_go = running & reload_req;
`else
    assign reload_go = 1'b0;
`endif

    // PC bits above the word index wrap the fetch address modulo DEPTH.
    logic unused_inputs;
    assign unused_inputs = ^{reload_req, cpu_pc[31:AW+2]};

    // NOTE: every state register is assigned with <= so all of them sample
    // the pre-edge values; blocking assignments here would create ordering
    // dependent behaviour between simulation and synthesis.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_LOAD;
            wcnt    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            boot_q  <= 1'b0;
            stall_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            // A write lasts exactly one cycle unless a handshake re-arms it.
            we_q <= 1'b0;

            case (state)
                ST_LOAD: begin
                    ready_q <= 1'b1;
                    stall_q <= 1'b1;
                    boot_q  <= 1'b0;
                    if (handshake) begin
                        we_q    <= 1'b1;
                        addr_q  <= wcnt[AW-1:0];
                        wdata_q <= ld_data;
                        wcnt    <= wcnt + 1'b1;
                        if (ld_last) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b0;
                        end else if (wcnt == LAST_WORD) begin
                            // Memory full and the image is still going.
                            state   <= ST_ERR;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    ready_q <= 1'b0;
                    if (stall_q) begin
                        // Final image word lands this cycle; release next.
                        stall_q <= 1'b0;
                        boot_q  <= 1'b1;
                    end else begin
                        if (pc_misaligned(cpu_pc[1:0])) begin
                            err_q <= 1'b1;
                        end
                        if (reload_go) begin
                            state   <= ST_LOAD;
                            wcnt    <= '0;
                            boot_q  <= 1'b0;
                            stall_q <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end

                ST_ERR: begin
                    ready_q <= 1'b0;
                    stall_q <= 1'b1;
                    boot_q  <= 1'b0;
                    err_q   <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: park safely with the CPU held.
                    state   <= ST_ERR;
                    ready_q <= 1'b0;
                    stall_q <= 1'b1;
                    boot_q  <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready  = ready_q;
    assign cpu_stall = stall_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign boot_done = boot_q;
    assign err       = err_q;
    assign mem_addr  = running ? cpu_pc[AW+1:2] : addr_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Self-checking bench for imem_load_ctrl. A behavioural model tracks the
// controller's phase, accepted word count and pending write; a compare
// process checks every DUT output against it on each falling clock edge.
// Directed scenarios add literal expectations and check the written image
// (address/data sequence) against the words the bench sent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_load_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    localparam int P_LOAD = 0;
    localparam int P_RUN  = 1;
    localparam int P_ERR  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic [31:0]   cpu_pc;
    logic          cpu_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          boot_done;
    logic          err;
    logic          reload_req;

    imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .cpu_pc     (cpu_pc),
        .cpu_stall  (cpu_stall),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .boot_done  (boot_done),
        .err        (err),
        .reload_req (reload_req)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    logic [31:0]      sent[$];   // words the loader handed over
    logic [AW+31:0]   obs[$];    // {addr, data} of every observed write

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase;
    bit          m_fresh;      // no edge seen since reset released
    bit          m_booted;     // final write done, CPU released
    int          m_cnt;        // words accepted in the current image
    bit          m_wr;
    logic [AW-1:0] m_addr;
    logic [31:0] m_data;
    bit          m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase  <= P_LOAD;
            m_fresh  <= 1'b1;
            m_booted <= 1'b0;
            m_cnt    <= 0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_data   <= '0;
            m_err    <= 1'b0;
        end else begin
            m_fresh <= 1'b0;
            m_wr    <= 1'b0;
            if (m_phase == P_LOAD && !m_fresh && ld_valid) begin
                m_wr   <= 1'b1;
                m_addr <= AW'(m_cnt % DEPTH);
                m_data <= ld_data;
                m_cnt  <= m_cnt + 1;
                if (ld_last) begin
                    m_phase  <= P_RUN;
                    m_booted <= 1'b0;
                end else if (m_cnt + 1 == DEPTH) begin
                    m_phase <= P_ERR;
                    m_err   <= 1'b1;
                end
            end else if (m_phase == P_RUN) begin
                if (!m_booted) begin
                    m_booted <= 1'b1;
                end else begin
                    if (cpu_pc[1:0] != 2'b00) m_err <= 1'b1;
`ifdef IMEM_RELOAD_EN
                    if (reload_req) begin
                        m_phase  <= P_LOAD;
                        m_cnt    <= 0;
                        m_booted <= 1'b0;
                    end
`endif
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            bit          live;
            logic [63:0] exp_v;
            logic [63:0] act_v;
            live  = (m_phase == P_RUN) && m_booted;
            exp_v = {21'd0, (m_phase == P_LOAD) && !m_fresh, !live, live, m_wr, m_err,
                     live ? cpu_pc[AW+1:2] : m_addr, m_data};
            act_v = {21'd0, ld_ready, cpu_stall, boot_done, mem_we, err, mem_addr, mem_wdata};
            check("cycle{rdy,stall,boot,we,err,addr,wdata}", act_v, exp_v);
        end
        if (mem_we === 1'b1) obs.push_back({mem_addr, mem_wdata});
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall", cpu_stall, 1);
        check("rst_ready", ld_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_boot", boot_done, 0);
        check("rst_err", err, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("ready_low_before_first_edge", ld_ready, 0);
        tick();
        check("ready_after_first_edge", ld_ready, 1);
    endtask

    task automatic load(input int n, input bit with_last, input int gap_pct);
        int acc;
        int budget;
        acc    = 0;
        budget = n * 8 + 40;
        sent.delete();
        while (acc < n && budget > 0) begin
            budget--;
            ld_data  = $urandom;
            ld_valid = ($urandom_range(99) >= gap_pct);
            ld_last  = with_last && ld_valid && (acc == n - 1);
            if (ld_valid && ld_ready) begin
                sent.push_back(ld_data);
                acc++;
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (acc < n) check("load_budget_expired", acc, n);
    endtask

    task automatic wait_boot();
        int budget;
        budget = 10;
        while (cpu_stall !== 1'b0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("boot_timeout", cpu_stall, 0);
    endtask

    // Compare the observed writes with the expected count and the words sent.
    task automatic check_image(input string name, input int n);
        int bad;
        bad = 0;
        check({name, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) begin
            if (obs[i] !== {AW'(i), sent[i]}) bad++;
        end
        check({name, "_content_errors"}, bad, 0);
    endtask

    task automatic run_cycles(input int n, input int misalign_pct);
        for (int i = 0; i < n; i++) begin
            cpu_pc = {$urandom_range(255), 24'd0} | {24'd0, 6'($urandom), 2'b00};
            if ($urandom_range(99) < misalign_pct) cpu_pc[1:0] = 2'($urandom_range(3, 1));
            tick();
        end
        cpu_pc = 32'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        cpu_pc     = 32'd0;
        reload_req = 1'b0;
        tick();
        cmp_en = 1'b1;

        // 4-word image, last on word 3
        do_reset();
        obs.delete();
        load(4, 1'b1, 0);
        @(negedge clk);
        check("last_write_we", mem_we, 1);
        check("last_write_addr", mem_addr, 3);
        check("stall_during_last_write", cpu_stall, 1);
        @(negedge clk);
        check("stall_released", cpu_stall, 0);
        check("boot_done", boot_done, 1);
        check("we_idle_in_run", mem_we, 0);
        tick();
        check_image("img4", 4);

        // fetch addressing and wrap
        cpu_pc = 32'h0000_000C;
        #1 check("fetch_0x0c", mem_addr, 3);
        cpu_pc = 32'h0000_010C;
        #1 check("fetch_0x10c_wrap", mem_addr, 3);
        tick();
        run_cycles(12, 0);
        check("err_clear_aligned_run", err, 0);

        // misaligned fetch
        cpu_pc = 32'h0000_0006;
        tick();
        @(negedge clk);
        check("misaligned_err", err, 1);
        check("misaligned_no_stall", cpu_stall, 0);
        tick();
        cpu_pc = 32'd0;

        // overflow: 64 words, never last
        do_reset();
        obs.delete();
        load(64, 1'b0, 30);
        tick();
        @(negedge clk);
        check_image("overflow", 64);
        check("overflow_err", err, 1);
        check("overflow_stall", cpu_stall, 1);
        check("overflow_ready", ld_ready, 0);
        ld_valid = 1'b1;
        repeat (3) tick();
        ld_valid = 1'b0;
        check("overflow_no_more_writes", obs.size(), 64);

        // reset mid-load, then a fresh 3-word image
        do_reset();
        load(2, 1'b0, 0);
        do_reset();
        obs.delete();
        load(3, 1'b1, 20);
        wait_boot();
        check_image("reload_after_reset", 3);
        check("reload_after_reset_err", err, 0);

        // reload request while running
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        @(negedge clk);
`ifdef IMEM_RELOAD_EN
        check("reload_stall", cpu_stall, 1);
        check("reload_boot_cleared", boot_done, 0);
        check("reload_err_kept", err, 0);
        tick();
        obs.delete();
        load(2, 1'b1, 0);
        wait_boot();
        check_image("reload_image", 2);
`else
        check("reload_ignored_stall", cpu_stall, 0);
        check("reload_ignored_boot", boot_done, 1);
        tick();
        obs.delete();
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        repeat (3) tick();
        ld_valid = 1'b0;
        check("reload_ignored_no_writes", obs.size(), 0);
`endif

        // randomized images
        for (int k = 0; k < 8; k++) begin
            int  n;
            bit  ovf;
            do_reset();
            obs.delete();
            ovf = ($urandom_range(3) == 0);
            n   = ovf ? DEPTH : $urandom_range(DEPTH, 1);
            load(n, !ovf, $urandom_range(50));
            repeat (2) tick();
            if (!ovf) begin
                wait_boot();
                run_cycles(20, 10);
            end
            check_image("random_image", n);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter AW, default 6, word-address width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ld_valid, input, 1, loader word valid.
REQ-006 SHALL have port ld_ready, output, 1, controller accepts a loader word.
REQ-007 SHALL have port ld_data, input, 32, instruction word to store.
REQ-008 SHALL have port ld_last, input, 1, marks the final word of an image.
REQ-009 SHALL have port cpu_pc, input, 32, CPU byte-address fetch PC.
REQ-010 SHALL have port cpu_stall, output, 1, CPU must hold its PC.
REQ-011 SHALL have port mem_we, output, 1, instruction-memory write enable.
REQ-012 SHALL have port mem_addr, output, AW, instruction-memory word address.
REQ-013 SHALL have port mem_wdata, output, 32, instruction-memory write data.
REQ-014 SHALL have port boot_done, output, 1, image loaded and CPU running.
REQ-015 SHALL have port err, output, 1, sticky overflow or misaligned-fetch error.
REQ-016 SHALL have port reload_req, input, 1, request a new image load; used only under IMEM_RELOAD_EN.

Function
REQ-017 SHALL implement the states LOAD, RUN and ERR; LOAD is entered from reset.
REQ-018 In LOAD, ld_ready SHALL be 1 and cpu_stall SHALL be 1; a handshake is ld_valid & ld_ready.
REQ-019 Each handshake SHALL register mem_we=1, mem_addr=wcnt and mem_wdata=ld_data for exactly the next cycle, then increment wcnt (width AW+1); sustained throughput is one word per cycle.
REQ-020 A handshake with ld_last=1 SHALL move the state to RUN; the write for that word still occurs in the following cycle.
REQ-021 A handshake at wcnt=DEPTH-1 with ld_last=0 SHALL write that word and move the state to ERR.
REQ-022 In RUN: ld_ready=0, cpu_stall=0, boot_done=1, mem_we=0 (once the final write has completed), and mem_addr=cpu_pc[AW+1:2], combinational.
REQ-023 In RUN, cpu_pc[1:0]!=0 SHALL set err at the next edge; the state remains RUN.
REQ-024 cpu_pc bits above AW+1 SHALL be ignored, so fetch addresses wrap modulo DEPTH words.
REQ-025 ERR SHALL hold cpu_stall=1, ld_ready=0 and err=1 until reset.
REQ-026 A cycle with ld_valid=0 SHALL leave wcnt and the state unchanged and produce mem_we=0.

Reset
REQ-027 Assertion of reset SHALL immediately force the state to LOAD and set wcnt=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, boot_done=0, cpu_stall=1 and ld_ready=0.
REQ-028 ld_ready SHALL rise in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-load SHALL abandon the partial image; the next load restarts at word 0.

Configuration
REQ-030 With IMEM_RELOAD_EN defined, reload_req=1 in RUN SHALL move the state to LOAD with wcnt=0, boot_done=0 and cpu_stall=1 at the next edge; err is unchanged.
REQ-031 Without IMEM_RELOAD_EN, reload_req SHALL be ignored and RUN is left only by reset.

Structure
REQ-032 The state encoding type, the default DEPTH and the default AW SHALL reside in the shared package imem_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the memory array stays outside the block.

Verification
REQ-034 Load 4 words with ld_last on word 3 -> mem_we pulses with addresses 0..3 carrying that data; cpu_stall falls one cycle after the last write; boot_done=1.
REQ-035 In RUN, drive cpu_pc=0x0C -> mem_addr=3; drive cpu_pc=0x10C -> mem_addr=3 (wrap).
REQ-036 Load 64 words with no ld_last -> 64 writes occur, then err=1, cpu_stall=1, ld_ready=0.
REQ-037 In RUN, drive cpu_pc=0x06 -> err=1 at the next edge; cpu_stall stays 0.
REQ-038 Assert reset after 2 of 5 words, then reload 3 words -> writes restart at address 0 and err=0.
REQ-039 With IMEM_RELOAD_EN, assert reload_req in RUN -> cpu_stall=1, then a 2-word load rewrites addresses 0..1; without the macro -> no change.
